// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, the data port, the shared memory bus and the stall
// outputs of the memory port arbiter into one connection.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_kill;
    logic [DW-1:0]   if_rdata;
    logic            if_done;

    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_be;
    logic [DW-1:0]   d_rdata;
    logic            d_done;

    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic            mem_ready;
    logic            mem_rvalid;
    logic [DW-1:0]   mem_rdata;

    logic            stall_if;
    logic            stall_mem;
    logic            busy;

    // The arbiter's own view of the bundle.
    modport slave (
        input  if_req, if_addr, if_kill,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        input  mem_ready, mem_rvalid, mem_rdata,
        output if_rdata, if_done, d_rdata, d_done,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output stall_if, stall_mem, busy
    );

    // The pipeline and memory side driving the arbiter.
    modport master (
        output if_req, if_addr, if_kill,
        output d_req, d_we, d_addr, d_wdata, d_be,
        output mem_ready, mem_rvalid, mem_rdata,
        input  if_rdata, if_done, d_rdata, d_done,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  stall_if, stall_mem, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and data memory,
// with data priority, a fetch starvation guard and flush-killed fetches.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} stateT;
    typedef enum logic {OWN_IF, OWN_D} ownerT;

    stateT           state, nextState;
    ownerT           owner;
    logic [CW-1:0]   starveCnt;
    logic            killFlag;
    logic            grantIf, grantD, killHit, captureIf, captureD;
    logic            ifDone, dDone;

    logic            memWe;
    logic [AW-1:0]   memAddr;
    logic [DW-1:0]   memWdata;
    logic [DW/8-1:0] memBe;
    logic [DW-1:0]   ifRdata;
    logic [DW-1:0]   dRdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // A kill landing in the same cycle as the response must already suppress the capture.
    always_comb begin
        nextState = state;
        grantIf   = 1'b0;
        grantD    = 1'b0;
        killHit   = 1'b0;
        captureIf = 1'b0;
        captureD  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.d_req && !(bus.if_req && starveCnt == CW'(STARVE_LIMIT))) begin
                    grantD    = 1'b1;
                    nextState = ISSUE;
                end else if (bus.if_req) begin
                    grantIf   = 1'b1;
                    nextState = ISSUE;
                end
            end
            ISSUE: begin
                killHit = bus.if_kill && owner == OWN_IF;
                if (bus.mem_ready) nextState = WAIT;
            end
            WAIT: begin
                killHit = bus.if_kill && owner == OWN_IF;
                if (bus.mem_rvalid) begin
                    nextState = DONE;
                    captureIf = owner == OWN_IF && !killFlag && !bus.if_kill;
                    captureD  = owner == OWN_D && !memWe;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= OWN_IF;
            starveCnt <= '0;
            killFlag  <= 1'b0;
        end else begin
            if (grantD) begin
                owner <= OWN_D;
                if (!bus.if_req)                          starveCnt <= '0;
                else if (starveCnt != CW'(STARVE_LIMIT)) starveCnt <= starveCnt + CW'(1);
            end
            if (grantIf) begin
                owner     <= OWN_IF;
                starveCnt <= '0;
            end
            if (state == DONE)  killFlag <= 1'b0;
            else if (killHit)   killFlag <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            memBe    <= '0;
            ifRdata  <= '0;
            dRdata   <= '0;
        end else begin
            if (grantD) begin
                memWe    <= bus.d_we;
                memAddr  <= bus.d_addr;
                memWdata <= bus.d_wdata;
                memBe    <= bus.d_be;
            end
            if (grantIf) begin
                memWe    <= 1'b0;
                memAddr  <= bus.if_addr;
                memWdata <= '0;
                memBe    <= '1;
            end
            if (captureIf) ifRdata <= bus.mem_rdata;
            if (captureD)  dRdata  <= bus.mem_rdata;
        end
    end

    assign ifDone = state == DONE && owner == OWN_IF && !killFlag;
    assign dDone  = state == DONE && owner == OWN_D;

    assign bus.mem_req   = state == ISSUE;
    assign bus.mem_we    = memWe;
    assign bus.mem_addr  = memAddr;
    assign bus.mem_wdata = memWdata;
    assign bus.mem_be    = memBe;
    assign bus.if_rdata  = ifRdata;
    assign bus.d_rdata   = dRdata;
    assign bus.if_done   = ifDone;
    assign bus.d_done    = dDone;
    assign bus.stall_if  = bus.if_req & ~ifDone;
    assign bus.stall_mem = bus.d_req & ~dDone;
    assign bus.busy      = state != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter, run with STARVE_LIMIT = 2
// so the starvation guard trips after two data grants.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checkCount = 0;
    int   passCount  = 0;
    logic gotIf, gotD;
    logic [31:0] seenAddr;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic dReq, input logic dWe, input logic [31:0] dAddr,
                                 input logic [31:0] dWdata, input logic [3:0] dBe);
        bus.d_req   = dReq;
        bus.d_we    = dWe;
        bus.d_addr  = dAddr;
        bus.d_wdata = dWdata;
        bus.d_be    = dBe;
    endtask

    // Serves one transaction with zero-wait handshakes; returns at the DONE negedge.
    task automatic serveOne(input logic [31:0] rdata, output logic ifDoneSeen,
                            output logic dDoneSeen, output logic [31:0] addr);
        bit found = 1'b0;
        ifDoneSeen = 1'b0;
        dDoneSeen  = 1'b0;
        addr       = '0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.mem_req) found = 1'b1;
        end
        if (!found) begin
            checkOutput("serve timeout", 32'd0, 32'd1);
        end else begin
            addr          = bus.mem_addr;
            bus.mem_ready = 1'b1;
            @(negedge clk);
            bus.mem_ready  = 1'b0;
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = rdata;
            @(negedge clk);
            ifDoneSeen     = bus.if_done;
            dDoneSeen      = bus.d_done;
            bus.mem_rvalid = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.if_kill    = 1'b0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        @(negedge clk);
        checkOutput("rst mem_req", bus.mem_req, 1'b0);
        checkOutput("rst mem_addr", bus.mem_addr, 32'h0);
        checkOutput("rst mem_be", bus.mem_be, 32'h0);
        checkOutput("rst busy", bus.busy, 1'b0);
        checkOutput("rst d_rdata", bus.d_rdata, 32'h0);
        checkOutput("rst if_rdata", bus.if_rdata, 32'h0);
        rst = 1'b0;

        // Lone load
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        #1 checkOutput("load stall_mem c0", bus.stall_mem, 1'b1);
        @(negedge clk);
        checkOutput("load mem_req c1", bus.mem_req, 1'b1);
        checkOutput("load mem_addr", bus.mem_addr, 32'h100);
        checkOutput("load mem_we", bus.mem_we, 1'b0);
        checkOutput("load stall_mem c1", bus.stall_mem, 1'b1);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        checkOutput("load mem_req c2", bus.mem_req, 1'b0);
        checkOutput("load d_done c2", bus.d_done, 1'b0);
        checkOutput("load stall_mem c2", bus.stall_mem, 1'b1);
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEADBEEF;
        @(negedge clk);
        checkOutput("load d_done c3", bus.d_done, 1'b1);
        checkOutput("load d_rdata", bus.d_rdata, 32'hDEADBEEF);
        checkOutput("load stall_mem c3", bus.stall_mem, 1'b0);
        bus.mem_rvalid = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("load d_done c4", bus.d_done, 1'b0);
        checkOutput("load busy c4", bus.busy, 1'b0);

        // Contention: store wins, then fetch
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h200;
        applyStimulus(1'b1, 1'b1, 32'h300, 32'h11223344, 4'b0011);
        @(negedge clk);
        checkOutput("cont mem_we", bus.mem_we, 1'b1);
        checkOutput("cont mem_addr d", bus.mem_addr, 32'h300);
        checkOutput("cont mem_wdata", bus.mem_wdata, 32'h11223344);
        checkOutput("cont mem_be d", bus.mem_be, 32'h3);
        checkOutput("cont stall_if c1", bus.stall_if, 1'b1);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hAAAA5555;
        checkOutput("cont stall_if c2", bus.stall_if, 1'b1);
        @(negedge clk);
        checkOutput("cont d_done", bus.d_done, 1'b1);
        checkOutput("cont store keeps d_rdata", bus.d_rdata, 32'hDEADBEEF);
        checkOutput("cont stall_if c3", bus.stall_if, 1'b1);
        bus.mem_rvalid = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("cont busy c4", bus.busy, 1'b0);
        checkOutput("cont stall_if c4", bus.stall_if, 1'b1);
        @(negedge clk);
        checkOutput("cont mem_req if", bus.mem_req, 1'b1);
        checkOutput("cont mem_addr if", bus.mem_addr, 32'h200);
        checkOutput("cont mem_we if", bus.mem_we, 1'b0);
        checkOutput("cont mem_be if", bus.mem_be, 32'hF);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hCAFEF00D;
        @(negedge clk);
        checkOutput("cont if_done", bus.if_done, 1'b1);
        checkOutput("cont if_rdata", bus.if_rdata, 32'hCAFEF00D);
        checkOutput("cont stall_if c7", bus.stall_if, 1'b0);
        bus.mem_rvalid = 1'b0;
        bus.if_req     = 1'b0;

        // Starvation guard: two data grants, then fetch is forced
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h400;
        applyStimulus(1'b1, 1'b0, 32'h500, 32'h0, 4'hF);
        serveOne(32'h01010101, gotIf, gotD, seenAddr);
        checkOutput("starve g1 d_done", gotD, 1'b1);
        checkOutput("starve g1 addr", seenAddr, 32'h500);
        checkOutput("starve g1 d_rdata", bus.d_rdata, 32'h01010101);
        serveOne(32'h02020202, gotIf, gotD, seenAddr);
        checkOutput("starve g2 d_done", gotD, 1'b1);
        checkOutput("starve g2 if_done", gotIf, 1'b0);
        serveOne(32'h03030303, gotIf, gotD, seenAddr);
        checkOutput("starve g3 if_done", gotIf, 1'b1);
        checkOutput("starve g3 d_done", gotD, 1'b0);
        checkOutput("starve g3 addr", seenAddr, 32'h400);
        checkOutput("starve g3 if_rdata", bus.if_rdata, 32'h03030303);
        checkOutput("starve cnt cleared", 32'(dut.starveCnt), 32'd0);
        bus.if_req = 1'b0;
        serveOne(32'h04040404, gotIf, gotD, seenAddr);
        checkOutput("starve g4 d_done", gotD, 1'b1);
        checkOutput("starve g4 d_rdata", bus.d_rdata, 32'h04040404);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Backpressure on a store
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 32'h600, 32'h0BADF00D, 4'b1100);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput($sformatf("bp mem_req %0d", i), bus.mem_req, 1'b1);
            checkOutput($sformatf("bp mem_addr %0d", i), bus.mem_addr, 32'h600);
            checkOutput($sformatf("bp mem_wdata %0d", i), bus.mem_wdata, 32'h0BADF00D);
            checkOutput($sformatf("bp mem_be %0d", i), bus.mem_be, 32'hC);
            if (i == 5) bus.mem_ready = 1'b1;
        end
        @(negedge clk);
        checkOutput("bp mem_req drop", bus.mem_req, 1'b0);
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h12345678;
        @(negedge clk);
        checkOutput("bp d_done", bus.d_done, 1'b1);
        checkOutput("bp d_rdata kept", bus.d_rdata, 32'h04040404);
        bus.mem_rvalid = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("bp d_done once", bus.d_done, 1'b0);
        checkOutput("bp busy idle", bus.busy, 1'b0);

        // Kill during WAIT of a fetch
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h700;
        @(negedge clk);
        checkOutput("kill mem_req", bus.mem_req, 1'b1);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.if_kill   = 1'b1;
        @(negedge clk);
        bus.if_kill = 1'b0;
        checkOutput("kill busy wait", bus.busy, 1'b1);
        checkOutput("kill mem_req wait", bus.mem_req, 1'b0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h99999999;
        @(negedge clk);
        checkOutput("kill if_done", bus.if_done, 1'b0);
        checkOutput("kill if_rdata kept", bus.if_rdata, 32'h03030303);
        checkOutput("kill busy done", bus.busy, 1'b1);
        bus.mem_rvalid = 1'b0;
        bus.if_req     = 1'b0;
        @(negedge clk);
        checkOutput("kill idle", bus.busy, 1'b0);
        checkOutput("kill if_done idle", bus.if_done, 1'b0);

        // Reset during WAIT, then recover
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h800, 32'h0, 4'hF);
        @(negedge clk);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("wrst busy", bus.busy, 1'b0);
        checkOutput("wrst mem_addr", bus.mem_addr, 32'h0);
        checkOutput("wrst mem_be", bus.mem_be, 32'h0);
        checkOutput("wrst d_rdata", bus.d_rdata, 32'h0);
        checkOutput("wrst if_rdata", bus.if_rdata, 32'h0);
        checkOutput("wrst d_done", bus.d_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        serveOne(32'h55AA55AA, gotIf, gotD, seenAddr);
        checkOutput("wrst recover d_done", gotD, 1'b1);
        checkOutput("wrst recover addr", seenAddr, 32'h800);
        checkOutput("wrst recover d_rdata", bus.d_rdata, 32'h55AA55AA);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        @(negedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single external memory port between the instruction-fetch stage and the data-memory stage of the 5-stage pipeline.
- Grants one transaction at a time: data side has priority, with a starvation guard for fetch.
- Sequences each transaction through a request/accept/response handshake.
- Produces per-stage stall requests that the hazard logic ORs into its existing stall and flush decisions.

## Interface
- AW, 32, address width
- DW, 32, data width; DW/8 byte enables
- STARVE_LIMIT, 4, consecutive data grants made while fetch is pending before fetch is forced; ≥1
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr stable until if_done
- if_addr  in  AW  fetch address
- if_kill  in  1  pipeline flush (taken branch/jump); cancels the outstanding fetch
- if_rdata  out  DW  registered fetch data
- if_done  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; held with attributes stable until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_be  in  DW/8  store byte enables
- d_rdata  out  DW  registered load data
- d_done  out  1  one-cycle completion pulse for data
- mem_req  out  1  bus request valid
- mem_we, mem_addr, mem_wdata, mem_be  out  1/AW/DW/DW/8  registered bus attributes
- mem_ready  in  1  bus accepts the request this cycle
- mem_rvalid  in  1  bus response valid; also used as the store acknowledge
- mem_rdata  in  DW  bus response data
- stall_if  out  1  if_req & ~if_done
- stall_mem  out  1  d_req & ~d_done
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. An owner register (IF or D) records the granted requester.
- IDLE: if any request is high, pick a winner, latch its attributes into the mem_* registers and set owner. Go to ISSUE.
  - Winner is data when d_req = 1, except when if_req = 1 and starve_cnt == STARVE_LIMIT; then the winner is fetch.
  - A fetch grant always has mem_we = 0 and mem_be = all ones.
- ISSUE: mem_req = 1. Go to WAIT on mem_ready = 1; otherwise hold.
- WAIT: mem_req = 0. On mem_rvalid, capture mem_rdata into the owner's rdata register (loads and fetches only; stores leave d_rdata unchanged). Go to DONE.
- DONE: assert the owner's done for exactly one cycle, then go to IDLE.
  - if_done = (state == DONE) & (owner == IF) & ~kill_flag.
  - Requests are not sampled in DONE.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on every data grant made while if_req = 1.
  - Clears on every fetch grant, and on every data grant made while if_req = 0.
- kill_flag:
  - Set by if_kill = 1 while owner == IF in ISSUE or WAIT.
  - Clears on entry to IDLE.
  - A killed transaction still completes on the bus. It produces no if_done and leaves if_rdata unchanged.
  - if_kill in IDLE or DONE, or while owner == D, has no effect.
- mem_rvalid outside WAIT and mem_ready outside ISSUE are ignored.

## Timing
- Reset (async, immediate): state IDLE, owner IF, starve_cnt 0, kill_flag 0.
  - Reset output values: mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_be 0, if_rdata 0, d_rdata 0, if_done 0, d_done 0, busy 0.
  - stall_* follow their requests combinationally.
  - Reset mid-transaction abandons it; the bus side must also be reset.
- Minimum latency from request to done, with mem_ready in the first ISSUE cycle and mem_rvalid in the first WAIT cycle:
  - req high at cycle 0 (IDLE)
  - mem_req at cycle 1
  - WAIT at cycle 2
  - done at cycle 3
- Back-to-back transactions: the next grant is made at the earliest in the IDLE cycle after DONE, so throughput is at most one transaction per 4 cycles.
- Simultaneous if_req and d_req in IDLE: data wins, unless the starvation guard applies. The loser stays stalled.
- done and the updated rdata are visible in the same cycle.

## Test plan
- Lone load: d_req with d_addr 0x100, mem_ready at cycle 1, mem_rvalid with 0xDEADBEEF at cycle 2 -> d_done only at cycle 3, d_rdata = 0xDEADBEEF, stall_mem 1 during cycles 0–2.
- Contention: if_req and d_req both high at cycle 0 -> the data transaction is served first; fetch is granted in the IDLE cycle after d_done; stall_if stays high throughout.
- Starvation guard with STARVE_LIMIT = 2: if_req held while d_req is re-raised after each d_done -> the third grant goes to fetch, and starve_cnt returns to 0.
- Bus backpressure: mem_ready low for 5 cycles, then a store -> mem_req and its attributes are held stable for 6 cycles; d_done pulses once; d_rdata is unchanged.
- Kill: if_kill pulsed during WAIT of a fetch -> no if_done pulse, if_rdata unchanged, FSM returns to IDLE after mem_rvalid.
- Reset asserted in WAIT -> all outputs return to their reset values immediately; after release, a new request completes normally.
